// File: rtl/main_mem_responder.sv
// Line-addressed main-memory responder for the 128-bit cache line bus.
// Accepts one request at a time and completes it after a fixed per-direction
// latency. It also watches the initiator for protocol violations and counts
// completed transactions.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (storage array is not reset)
//   mem_req    request valid, held by the initiator until mem_ready
//   mem_we     1 = line write, 0 = line read
//   mem_addr   byte address; only [DEPTH_LOG2+3:4] selects the line
//   mem_wdata  write line
//   mem_rdata  read line, valid while mem_ready=1 on reads
//   mem_ready  one-cycle completion pulse
//   proto_err  sticky initiator protocol violation flag
//   rd_cnt     completed reads (wraps)
//   wr_cnt     completed writes (wraps)
module main_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [31:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         proto_err,
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam logic [7:0]  RdLatM1 = 8'(RD_LAT - 1);
  localparam logic [7:0]  WrLatM1 = 8'(WR_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    req_we_q;
  logic [DEPTH_LOG2-1:0]   req_idx_q;
  logic [127:0]            req_wdata_q;
  logic [127:0]            rdata_q;
  logic                    ready_q;
  logic                    proto_err_q;
  logic [31:0]             rd_cnt_q;
  logic [31:0]             wr_cnt_q;

  logic [127:0]            mem_array [Depth];

  logic [DEPTH_LOG2-1:0]   live_idx;
  logic [7:0]              lat_m1;
  logic                    accept;
  logic                    resp_entry;
  logic                    mismatch;
  logic                    eff_we;
  logic [DEPTH_LOG2-1:0]   eff_idx;
  logic [127:0]            eff_wdata;
  logic                    mem_wr;

  // Byte offset and alias bits above the line index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:DEPTH_LOG2+4], mem_addr[3:0]};

  assign live_idx = mem_addr[DEPTH_LOG2+3:4];
  assign lat_m1   = mem_we ? WrLatM1 : RdLatM1;
  assign accept   = (state_q == StIdle) && mem_req;

  // A latency of 1 goes straight from IDLE to RESP, before the request register
  // has been loaded, so the completion uses the live bus in that case.
  assign eff_we    = (state_q == StIdle) ? mem_we    : req_we_q;
  assign eff_idx   = (state_q == StIdle) ? live_idx  : req_idx_q;
  assign eff_wdata = (state_q == StIdle) ? mem_wdata : req_wdata_q;

  assign resp_entry = (state_d == StResp) && (state_q != StResp);

  // Checked on every edge taken from BUSY, which includes the edge entering RESP.
  assign mismatch = (state_q == StBusy) &&
                    (!mem_req || (mem_we != req_we_q) || (live_idx != req_idx_q) ||
                     (req_we_q && (mem_wdata != req_wdata_q)));

  // Gated by rst_n so a request seen while held in reset cannot touch the array.
  assign mem_wr = rst_n && resp_entry && eff_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (mem_req) begin
          cnt_d   = lat_m1;
          state_d = (lat_m1 == 8'd0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // Initiator still holds mem_req here; it is not a new request.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      req_we_q    <= 1'b0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      proto_err_q <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= resp_entry;
      proto_err_q <= proto_err_q | mismatch;
      if (accept) begin
        req_we_q    <= mem_we;
        req_idx_q   <= live_idx;
        req_wdata_q <= mem_wdata;
      end
      if (resp_entry) begin
        if (eff_we) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rdata_q  <= mem_array[eff_idx];
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end
    end
  end

  // Backing store has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_array[eff_idx] <= eff_wdata;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign proto_err = proto_err_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder. Three instances with different
// latencies (4/4 default, 1/1, 3/6) share one reset; only one is driven at a
// time. The driver updates a line-array reference model and pushes the
// expected completion; a negedge monitor pops and compares on every mem_ready.
module tb_main_mem_responder;

  localparam int NDut = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic         req   [NDut];
  logic         we    [NDut];
  logic [31:0]  addr  [NDut];
  logic [127:0] wdata [NDut];
  logic [127:0] rdata [NDut];
  logic         rdy   [NDut];
  logic         perr  [NDut];
  logic [31:0]  rdc   [NDut];
  logic [31:0]  wrc   [NDut];

  int lat_rd [NDut] = '{4, 1, 3};
  int lat_wr [NDut] = '{4, 1, 6};

  main_mem_responder u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .proto_err(perr[0]),
    .rd_cnt(rdc[0]), .wr_cnt(wrc[0])
  );

  main_mem_responder #(.DEPTH_LOG2(10), .RD_LAT(1), .WR_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .proto_err(perr[1]),
    .rd_cnt(rdc[1]), .wr_cnt(wrc[1])
  );

  main_mem_responder #(.DEPTH_LOG2(10), .RD_LAT(3), .WR_LAT(6)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[2]), .mem_we(we[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ready(rdy[2]), .proto_err(perr[2]),
    .rd_cnt(rdc[2]), .wr_cnt(wrc[2])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           d;
    int           cyc;
    logic [127:0] rdata;
    logic [31:0]  rdc;
    logic [31:0]  wrc;
    logic         perr;
  } exp_t;

  exp_t sb[$];

  // Reference model: per-instance line array and observable state.
  logic [127:0] mdl_mem   [NDut][1024];
  logic [127:0] mdl_rdata [NDut];
  logic [31:0]  mdl_rd    [NDut];
  logic [31:0]  mdl_wr    [NDut];
  logic         mdl_perr  [NDut];

  int  checks = 0;
  int  errors = 0;
  bit  resp_pending = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDut; d++) begin
      mdl_rdata[d] = '0;
      mdl_rd[d]    = '0;
      mdl_wr[d]    = '0;
      mdl_perr[d]  = 1'b0;
    end
  endtask

  // Monitor: every mem_ready pulse must match the oldest expected completion.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < NDut; d++) begin
      if (rdy[d] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 128'(d), 128'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("ready_instance", 128'(d), 128'(e.d));
          chk("ready_cycle", 128'(cyc), 128'(e.cyc));
          chk("rdata", rdata[d], e.rdata);
          chk("rd_cnt", 128'(rdc[d]), 128'(e.rdc));
          chk("wr_cnt", 128'(wrc[d]), 128'(e.wrc));
          chk("proto_err", 128'(perr[d]), 128'(e.perr));
        end
      end
    end
  end

  // mode: 0 normal, 1 keep mem_req high into next request,
  //       2 change address mid-transaction, 3 drop mem_req mid-transaction.
  task automatic txn(input int d, input bit w, input logic [31:0] a,
                     input logic [127:0] wd, input int mode);
    int           acc;
    int           lat;
    int           n;
    bit           seen;
    logic [9:0]   idx;
    exp_t         e;
    idx      = a[13:4];
    lat      = w ? lat_wr[d] : lat_rd[d];
    acc      = resp_pending ? cyc + 2 : cyc + 1;
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = w ? wd : rnd128();
    if (w) begin
      mdl_mem[d][idx] = wd;
      mdl_wr[d]       = mdl_wr[d] + 32'd1;
    end else begin
      mdl_rdata[d] = mdl_mem[d][idx];
      mdl_rd[d]    = mdl_rd[d] + 32'd1;
    end
    if ((mode == 2 || mode == 3) && lat >= 3) mdl_perr[d] = 1'b1;
    e.d = d; e.cyc = acc + lat - 1; e.rdata = mdl_rdata[d];
    e.rdc = mdl_rd[d]; e.wrc = mdl_wr[d]; e.perr = mdl_perr[d];
    sb.push_back(e);
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (cyc == acc + 1) begin
        if (!w) wdata[d] = rnd128();
        if (mode == 2) addr[d] = addr[d] ^ 32'h10;
        if (mode == 3) req[d] = 1'b0;
      end
      if (rdy[d] === 1'b1) seen = 1;
    end
    if (!seen) chk("ready_timeout", 128'(seen), 128'd1);
    if (mode == 1) begin
      resp_pending = 1;
    end else begin
      req[d] = 1'b0;
      @(posedge clk);
      #1;
      resp_pending = 0;
    end
  endtask

  function automatic logic [9:0] line_of(input int i);
    return (i < 16) ? 10'(i) : 10'(992 + i);
  endfunction

  function automatic logic [31:0] rnd_addr(input logic [9:0] idx);
    logic [31:0] a;
    a       = $urandom;
    a[13:4] = idx;
    return a;
  endfunction

  initial begin
    logic [127:0] pre80;
    for (int d = 0; d < NDut; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    model_reset();

    // Reset state.
    #1 rst_n = 1'b0;
    #10;
    for (int d = 0; d < NDut; d++) begin
      chk("reset_ready", 128'(rdy[d]), 128'd0);
      chk("reset_rdata", rdata[d], 128'd0);
      chk("reset_proto_err", 128'(perr[d]), 128'd0);
      chk("reset_rd_cnt", 128'(rdc[d]), 128'd0);
      chk("reset_wr_cnt", 128'(wrc[d]), 128'd0);
    end
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle: no request, no ready.
    repeat (20) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDut; d++) chk("idle_ready", 128'(rdy[d]), 128'd0);
    end

    // Preload a window of low and high lines, then random traffic per instance.
    for (int d = 0; d < NDut; d++) begin
      for (int i = 0; i < 32; i++) txn(d, 1'b1, rnd_addr(line_of(i)), rnd128(), 0);
      for (int k = 0; k < 40; k++) begin
        int m;
        m = (k != 39 && $urandom_range(0, 2) == 0) ? 1 : 0;
        txn(d, 1'($urandom_range(0, 1)), rnd_addr(line_of($urandom_range(0, 31))),
            rnd128(), m);
      end
    end

    // Write then read the same line; aliasing of offset and upper address bits.
    txn(0, 1'b1, 32'h0000_0040, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
    txn(0, 1'b0, 32'h0000_0040, '0, 0);
    txn(0, 1'b1, 32'h0000_4048, {16{8'hAA}}, 0);
    txn(0, 1'b0, 32'h0000_0040, '0, 0);

    // Back-to-back reads with mem_req held through ready.
    txn(0, 1'b0, 32'h0000_0040, '0, 1);
    txn(0, 1'b0, 32'h0000_0050, '0, 1);
    txn(0, 1'b0, 32'h0000_0040, '0, 0);

    // Address changed mid-read: flagged, but completes with line 0x40.
    txn(0, 1'b0, 32'h0000_0040, '0, 2);
    txn(0, 1'b1, 32'h0000_0030, rnd128(), 0);

    // Reset two cycles into a write of line 0x80: write discarded.
    pre80    = mdl_mem[0][8];
    req[0]   = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0080; wdata[0] = {16{8'h55}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b0;
    req[0] = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_ready", 128'(rdy[0]), 128'd0);
    chk("rst_mid_rdata", rdata[0], 128'd0);
    chk("rst_mid_proto_err", 128'(perr[0]), 128'd0);
    chk("rst_mid_wr_cnt", 128'(wrc[0]), 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("post_rst_ready", 128'(rdy[0]), 128'd0);
    end
    chk("model_line80_kept", mdl_mem[0][8], pre80);
    txn(0, 1'b0, 32'h0000_0080, '0, 0);

    // mem_req dropped mid-BUSY: flagged, still completes, flag stays set.
    txn(0, 1'b0, 32'h0000_1230, '0, 3);
    txn(0, 1'b1, rnd_addr(line_of(5)), rnd128(), 0);
    txn(0, 1'b0, rnd_addr(line_of(5)), '0, 0);

    // Latency-1 instance: ready at t0+1, one idle cycle between completions.
    txn(1, 1'b0, rnd_addr(line_of(3)), '0, 1);
    txn(1, 1'b0, rnd_addr(line_of(20)), '0, 1);
    txn(1, 1'b1, rnd_addr(line_of(3)), rnd128(), 1);
    txn(1, 1'b0, rnd_addr(line_of(3)), '0, 0);

    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
